// File: rtl/axicb_pkg.sv
// Shared types and helpers for the crossbar write-data scheduler.
package axicb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2
    } wsched_state_e;

    // Attribute FIFO depth: next power of two of the outstanding limit, at least 2.
    function automatic int unsigned wdata_fifo_depth(input int unsigned ostd_num);
        int unsigned n;
        n = (ostd_num < 32'd2) ? 32'd2 : ostd_num;
        return 32'd1 << $clog2(n);
    endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// Single-clock register-file FIFO with registered full/empty flags.
module axicb_scfifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pull,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_n;
    logic                  push_ok;
    logic                  pull_ok;

    assign push_ok  = push & ~full;
    assign pull_ok  = pull & ~empty;
    assign data_out = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({push_ok, pull_ok})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pull_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/axicb_wdata_sched.sv
// Write-data scheduler: steers each W burst to the slave granted the matching AW,
// draining misrouted bursts locally and flagging beat-count mismatches.
module axicb_wdata_sched
    import axicb_pkg::*;
#(
    parameter int unsigned SLV_NB          = 4,
    parameter int unsigned MST_OSTDREQ_NUM = 4
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              aw_valid,
    input  logic              aw_ready,
    output logic              aw_full,
    input  logic [SLV_NB-1:0] aw_ix,
    input  logic              aw_mr,
    input  logic [7:0]        aw_len,
    input  logic              w_valid,
    input  logic              w_last,
    output logic              w_ready,
    output logic [SLV_NB-1:0] s_wvalid,
    input  logic [SLV_NB-1:0] s_wready,
    output logic [SLV_NB-1:0] w_grant,
    output logic              mr_wdone,
    output logic              len_err
);

    localparam int unsigned FIFO_DEPTH = wdata_fifo_depth(MST_OSTDREQ_NUM);
    localparam int unsigned ATTR_W     = 8 + SLV_NB + 1;

    wsched_state_e     state_q, state_n;
    logic [SLV_NB-1:0] cur_ix_q, cur_ix_n;
    logic [7:0]        cur_len_q, cur_len_n;
    logic [7:0]        beat_cnt_q, beat_cnt_n;
    logic              len_err_q, len_err_n;
    logic              mr_wdone_q, mr_wdone_n;

    logic              push;
    logic              pop;
    logic              beat;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ATTR_W-1:0] attr_in;
    logic [ATTR_W-1:0] attr_head;
    logic              head_mr;
    logic [SLV_NB-1:0] head_ix;
    logic [7:0]        head_len;

    // Attribute record layout: {len, ix, mr}.
    assign push     = aw_valid & aw_ready;
    assign attr_in  = {aw_len, aw_ix, aw_mr};
    assign head_mr  = attr_head[0];
    assign head_ix  = attr_head[SLV_NB:1];
    assign head_len = attr_head[ATTR_W-1 -: 8];

    assign aw_full  = fifo_full;
    assign mr_wdone = mr_wdone_q;
    assign len_err  = len_err_q;

    axicb_scfifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (ATTR_W)
    ) u_attr_fifo (
        .aclk     (aclk),
        .aresetn  (1'b1),
        .srst     (srst),
        .push     (push),
        .data_in  (attr_in),
        .pull     (pop),
        .data_out (attr_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Next-state, steering and end-of-burst bookkeeping.
    always_comb begin
        state_n    = state_q;
        cur_ix_n   = cur_ix_q;
        cur_len_n  = cur_len_q;
        beat_cnt_n = beat_cnt_q;
        len_err_n  = 1'b0;
        mr_wdone_n = 1'b0;
        pop        = 1'b0;
        w_ready    = 1'b0;
        s_wvalid   = '0;
        w_grant    = '0;

        case (state_q)
            ROUTE: begin
                w_grant  = cur_ix_q;
                s_wvalid = cur_ix_q & {SLV_NB{w_valid}};
                w_ready  = |(cur_ix_q & s_wready);
            end
            DRAIN: begin
                w_ready = 1'b1;
            end
            default: begin
            end
        endcase

        beat = w_valid & w_ready;

        if (state_q == IDLE) begin
            pop = ~fifo_empty;
        end else if (beat) begin
            beat_cnt_n = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
            if (w_last) begin
                len_err_n  = (beat_cnt_q != cur_len_q);
                mr_wdone_n = (state_q == DRAIN);
                pop        = ~fifo_empty;
                state_n    = IDLE;
            end
        end

        // Loading the next head overrides the return to IDLE, so bursts chain without a bubble.
        if (pop) begin
            cur_ix_n   = head_ix;
            cur_len_n  = head_len;
            beat_cnt_n = '0;
            state_n    = head_mr ? DRAIN : ROUTE;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q    <= IDLE;
            cur_ix_q   <= '0;
            cur_len_q  <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
            mr_wdone_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cur_ix_q   <= cur_ix_n;
            cur_len_q  <= cur_len_n;
            beat_cnt_q <= beat_cnt_n;
            len_err_q  <= len_err_n;
            mr_wdone_q <= mr_wdone_n;
        end
    end

    // Upstream must hold off AW while full; such a push would be dropped.
    always_ff @(posedge aclk) begin
        if (!srst) begin
            assert (!(push && fifo_full))
                else $error("axicb_wdata_sched: AW pushed while attribute FIFO full");
        end
    end

endmodule

// File: tb/tb_axicb_wdata_sched.sv
// Directed and randomized checks of the write-data scheduler against a queue-based model.
module tb_axicb_wdata_sched;

    localparam int unsigned SLV_NB = 4;
    localparam int unsigned OSTD   = 4;
    localparam int unsigned DEPTH  = 4;

    typedef struct {
        logic [3:0] ix;
        logic       mr;
        logic [7:0] len;
    } attr_t;

    logic       aclk = 1'b0;
    logic       srst;
    logic       aw_valid, aw_ready, aw_full, aw_mr;
    logic [3:0] aw_ix;
    logic [7:0] aw_len;
    logic       w_valid, w_last, w_ready;
    logic [3:0] s_wvalid, s_wready, w_grant;
    logic       mr_wdone, len_err;

    always #5 aclk = ~aclk;

    axicb_wdata_sched #(
        .SLV_NB          (SLV_NB),
        .MST_OSTDREQ_NUM (OSTD)
    ) dut (
        .aclk     (aclk),
        .srst     (srst),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .aw_full  (aw_full),
        .aw_ix    (aw_ix),
        .aw_mr    (aw_mr),
        .aw_len   (aw_len),
        .w_valid  (w_valid),
        .w_last   (w_last),
        .w_ready  (w_ready),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .w_grant  (w_grant),
        .mr_wdone (mr_wdone),
        .len_err  (len_err)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: queued attributes, the burst in progress, pending pulses.
    attr_t      aq[$];
    attr_t      cur;
    logic       act = 1'b0;
    int         c_beats = 0;
    logic       e_len_err = 1'b0, e_mr_wdone = 1'b0;
    logic [3:0] e_grant, e_swv;
    logic       e_wr, e_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // Sample after inputs settle and compare every output against the model.
    task automatic settle();
        #2;
        e_grant = (act && !cur.mr) ? cur.ix : 4'b0000;
        e_swv   = e_grant & {4{w_valid}};
        e_wr    = act && (cur.mr || (|(cur.ix & s_wready)));
        e_full  = (aq.size() == DEPTH);
        chk("w_ready",  32'(w_ready),  32'(e_wr));
        chk("s_wvalid", 32'(s_wvalid), 32'(e_swv));
        chk("w_grant",  32'(w_grant),  32'(e_grant));
        chk("aw_full",  32'(aw_full),  32'(e_full));
        chk("len_err",  32'(len_err),  32'(e_len_err));
        chk("mr_wdone", 32'(mr_wdone), 32'(e_mr_wdone));
    endtask

    // Advance the model across the coming edge, then move to just after it.
    task automatic tick();
        logic  beat;
        attr_t a;
        beat = w_valid && e_wr;
        if (srst) begin
            aq.delete();
            act        = 1'b0;
            c_beats    = 0;
            e_len_err  = 1'b0;
            e_mr_wdone = 1'b0;
        end else begin
            e_len_err  = 1'b0;
            e_mr_wdone = 1'b0;
            if (act && beat) begin
                c_beats++;
                if (w_last) begin
                    e_len_err  = (c_beats != int'(cur.len) + 1);
                    e_mr_wdone = cur.mr;
                    act        = 1'b0;
                end
            end
            if (!act && aq.size() > 0) begin
                cur     = aq.pop_front();
                act     = 1'b1;
                c_beats = 0;
            end
            if (aw_valid && aw_ready) begin
                a.ix  = aw_ix;
                a.mr  = aw_mr;
                a.len = aw_len;
                aq.push_back(a);
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_push(input logic [3:0] ix, input logic mr, input logic [7:0] len);
        aw_valid = 1'b1;
        aw_ready = 1'b1;
        aw_ix    = ix;
        aw_mr    = mr;
        aw_len   = len;
        settle();
        tick();
        aw_valid = 1'b0;
        aw_ready = 1'b0;
    endtask

    initial begin
        int    wq[$];
        int    w_sent;
        int    gen;
        logic  hs, beat_now;

        srst = 1'b1; aw_valid = 1'b0; aw_ready = 1'b0; aw_ix = '0; aw_mr = 1'b0; aw_len = '0;
        w_valid = 1'b0; w_last = 1'b0; s_wready = '0;

        // Reset values.
        @(posedge aclk); #1;
        settle();
        chk("rst_w_ready", 32'(w_ready), 32'd0);
        chk("rst_aw_full", 32'(aw_full), 32'd0);
        tick();
        srst = 1'b0;

        // Single routed burst, len 3 to slave 1.
        aw_push(4'b0010, 1'b0, 8'd3);
        w_valid = 1'b1; w_last = 1'b0; s_wready = 4'b0010;
        settle();
        chk("t1_no_beat_k1", 32'(w_ready), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            w_last = (i == 3);
            settle();
            chk("t1_ready",  32'(w_ready),  32'd1);
            chk("t1_swvalid", 32'(s_wvalid), 32'h2);
            chk("t1_grant",  32'(w_grant),  32'h2);
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        settle();
        chk("t1_no_len_err", 32'(len_err), 32'd0);
        tick();

        // Back-to-back bursts: slave 0 len 1, then slave 3 len 0.
        aw_push(4'b0001, 1'b0, 8'd1);
        aw_push(4'b1000, 1'b0, 8'd0);
        w_valid = 1'b1; s_wready = 4'b1111;
        w_last = 1'b0; settle(); chk("t2_grant0_b0", 32'(w_grant), 32'h1); tick();
        w_last = 1'b1; settle(); chk("t2_grant0_b1", 32'(w_grant), 32'h1); tick();
        settle();
        chk("t2_no_bubble_grant", 32'(w_grant),  32'h8);
        chk("t2_no_bubble_valid", 32'(s_wvalid), 32'h8);
        chk("t2_no_bubble_ready", 32'(w_ready),  32'd1);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        settle(); tick();

        // Misrouted burst of 8 beats is drained.
        aw_push(4'b0100, 1'b1, 8'd7);
        w_valid = 1'b1; w_last = 1'b0;
        settle(); chk("t3_idle_stall", 32'(w_ready), 32'd0); tick();
        for (int i = 0; i < 8; i++) begin
            w_last   = (i == 7);
            s_wready = 4'($urandom);
            settle();
            chk("t3_drain_ready", 32'(w_ready),  32'd1);
            chk("t3_drain_swv",   32'(s_wvalid), 32'd0);
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        settle(); chk("t3_mr_wdone", 32'(mr_wdone), 32'd1); tick();
        settle(); chk("t3_mr_wdone_once", 32'(mr_wdone), 32'd0); tick();

        // Length error: len 3 ends after 2 beats; next burst follows immediately.
        aw_push(4'b0001, 1'b0, 8'd3);
        aw_push(4'b0100, 1'b0, 8'd0);
        w_valid = 1'b1; s_wready = 4'b1111;
        w_last = 1'b0; settle(); tick();
        w_last = 1'b1; settle(); tick();
        settle();
        chk("t4_len_err", 32'(len_err), 32'd1);
        chk("t4_next_grant", 32'(w_grant), 32'h4);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        settle(); chk("t4_len_err_once", 32'(len_err), 32'd0); tick();

        // FIFO full: one entry is loaded, four more fill the FIFO.
        for (int i = 0; i < 5; i++) begin
            aw_valid = 1'b1; aw_ready = 1'b1; aw_ix = 4'b0001; aw_mr = 1'b0; aw_len = 8'd0;
            settle();
            if (i == 4) chk("t5_not_full_yet", 32'(aw_full), 32'd0);
            tick();
        end
        aw_valid = 1'b0; aw_ready = 1'b0;
        w_valid = 1'b1; w_last = 1'b1; s_wready = 4'b0001;
        settle(); chk("t5_full", 32'(aw_full), 32'd1); tick();
        for (int j = 0; j < 4; j++) begin
            settle();
            if (j == 0) chk("t5_full_clear", 32'(aw_full), 32'd0);
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        settle(); tick();

        // Reset mid-burst flushes the FIFO and abandons the burst.
        aw_push(4'b0010, 1'b0, 8'd3);
        aw_push(4'b0100, 1'b0, 8'd1);
        w_valid = 1'b1; w_last = 1'b0; s_wready = 4'b1111;
        settle(); tick();
        settle(); tick();
        w_valid = 1'b0; srst = 1'b1;
        settle(); tick();
        srst = 1'b0;
        w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_flushed", 32'(w_ready), 32'd0);
            tick();
        end
        aw_push(4'b1000, 1'b0, 8'd1);
        settle(); tick();
        settle(); chk("t6_after_grant", 32'(w_grant), 32'h8); tick();
        w_last = 1'b1; settle(); tick();
        w_valid = 1'b0; w_last = 1'b0;
        settle(); chk("t6_after_len_ok", 32'(len_err), 32'd0); tick();

        // Randomized traffic, including W ahead of AW and wrong beat counts.
        w_sent = 0;
        gen    = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!aw_valid && gen < 120 && $urandom_range(0, 2) == 0) begin
                aw_ix    = 4'(32'd1 << $urandom_range(0, 3));
                aw_mr    = ($urandom_range(0, 4) == 0);
                aw_len   = 8'($urandom_range(0, 7));
                aw_valid = 1'b1;
                wq.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9))
                                                        : int'(aw_len) + 1);
                gen++;
            end
            aw_ready = ($urandom_range(0, 3) != 0) && (aq.size() < DEPTH);
            s_wready = 4'($urandom);
            w_valid  = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
            w_last   = (wq.size() > 0) ? (w_sent == wq[0] - 1) : 1'b0;
            settle();
            hs       = aw_valid & aw_ready;
            beat_now = w_valid & e_wr;
            tick();
            if (hs) aw_valid = 1'b0;
            if (beat_now) begin
                w_sent++;
                if (w_last) begin
                    void'(wq.pop_front());
                    w_sent = 0;
                end
            end
        end
        chk("rand_all_drained", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
